// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring shift-subtract unsigned divider with valid/ready handshake
module seq_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_div_a,
    input  logic [DATA_WIDTH-1:0] in_div_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_quotient,
    output logic [DATA_WIDTH-1:0] out_remainder,
    output logic                  out_div_by_zero
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] quot;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] divisor;

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quot_next;
    logic                  accept;
    logic                  b_zero;
    logic                  last_iter;

    assign in_ready  = enable & (state == IDLE) & ~rst;
    assign out_valid = enable & (state == DONE) & ~rst;
    assign accept    = in_valid & in_ready;
    assign b_zero    = (in_div_b == '0);
    assign last_iter = (cnt == CW'(1));

    // The remainder register never exceeds the divisor, so only the shifted
    // value and the trial difference need the extra borrow bit.
    always_comb begin
        shifted   = {rem, quot[DATA_WIDTH-1]};
        trial     = shifted - {1'b0, divisor};
        rem_next  = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
        quot_next = {quot[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = b_zero ? DONE : CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            quot            <= '0;
            rem             <= '0;
            divisor         <= '0;
            out_quotient    <= '0;
            out_remainder   <= '0;
            out_div_by_zero <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        quot    <= in_div_a;
                        divisor <= in_div_b;
                        rem     <= '0;
                        cnt     <= CW'(DATA_WIDTH);
                        if (b_zero) begin
                            out_quotient    <= '1;
                            out_remainder   <= in_div_a;
                            out_div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    cnt  <= cnt - CW'(1);
                    // Result is published on the same edge as the final iteration.
                    if (last_iter) begin
                        out_quotient    <= quot_next;
                        out_remainder   <= rem_next;
                        out_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and random self-checking bench for seq_divider
module tb_seq_divider;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_div_a;
    logic [W-1:0] in_div_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_div_by_zero;

    int tests = 0;
    int fails = 0;
    int n;
    logic busy_rdy;

    seq_divider #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_div_a(in_div_a), .in_div_b(in_div_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_div_by_zero(out_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n++;
        if (in_ready) busy_rdy = 1'b1;
    endtask

    // Present operands in IDLE; n counts edges with the accept edge as 1.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("start_ready", in_ready, 1);
        in_div_a = a;
        in_div_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        busy_rdy = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic dz, input int lat);
        while (!out_valid && n < 300) step();
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_ready"}, busy_rdy, 0);
        chk({tag, "_q"}, out_quotient, q);
        chk({tag, "_r"}, out_remainder, r);
        chk({tag, "_dz"}, out_div_by_zero, dz);
    endtask

    task automatic handshake(input string tag, input logic [W-1:0] q);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
        chk({tag, "_q_held"}, out_quotient, q);
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r, input logic dz, input int lat);
        start(a, b);
        wait_done(tag, q, r, dz, lat);
        handshake(tag, q);
    endtask

    initial begin
        logic [W-1:0] ra, rb, mq, mr, q_hold, r_hold;
        int sel;
        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_div_a = '0; in_div_b = '0; n = 0; busy_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", out_quotient, 0);
        chk("rst_r", out_remainder, 0);
        chk("rst_dz", out_div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        op("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        op("divzero", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
        op("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        op("small", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
        op("zero_num", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 33);
        op("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);

        // Backpressure with ignored in_valid pulses, then back-to-back ops.
        start(32'd77, 32'd10);
        wait_done("bp", 32'd7, 32'd7, 1'b0, 33);
        for (int i = 0; i < 10; i++) begin
            in_div_a = 32'd999; in_div_b = 32'd2; in_valid = i[0];
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_q", out_quotient, 32'd7);
            chk("bp_r", out_remainder, 32'd7);
        end
        in_valid = 1'b0;
        handshake("bp", 32'd7);
        op("b2b_a", 32'd1234567, 32'd1000, 32'd1234, 32'd567, 1'b0, 33);
        op("b2b_b", 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, 33);

        // Stall at iteration 12.
        start(32'd1000, 32'd33);
        repeat (12) step();
        enable = 1'b0;
        repeat (5) begin
            step();
            chk("stall_valid", out_valid, 0);
            chk("stall_ready", in_ready, 0);
        end
        enable = 1'b1;
        wait_done("stall", 32'd30, 32'd10, 1'b0, 38);
        handshake("stall", 32'd30);

        // Reset at iteration 20 abandons the op.
        start(32'd100, 32'd7);
        repeat (20) step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", in_ready, 1);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_q", out_quotient, 0);
        chk("midrst_r", out_remainder, 0);
        op("after_rst", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = 32'd1;
            else if (sel < 5) rb = $urandom_range(2, 1000);
            else rb = $urandom;
            if (sel == 2) ra = $urandom_range(0, 50);
            mq = (rb == 0) ? '1 : ra / rb;
            mr = (rb == 0) ? ra : ra % rb;
            start(ra, rb);
            wait_done("rand", mq, mr, rb == 0, (rb == 0) ? 1 : 33);
            q_hold = out_quotient;
            r_hold = out_remainder;
            if (rb != 0) chk("rand_identity", {32'd0, q_hold} * {32'd0, rb} + {32'd0, r_hold}, {32'd0, ra});
            handshake("rand", mq);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
